mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one mem_ctrl port between N_REQ cache requesters.
// Grants one whole-block transaction at a time, routes ack to the granted
// requester only, and inserts a cs-low RELEASE cycle between transactions.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer); default build is round-robin.

package mem_arbiter_pkg;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BLOCK_SIZE = 16;
    localparam int unsigned BLOCK_W    = BLOCK_SIZE * 8;

    typedef struct packed {
        logic               cs;
        logic               rw;
        logic [ADDR_W-1:0]  addr;
        logic [BLOCK_W-1:0] data;
    } memory_request_t;

    typedef struct packed {
        logic               ack;
        logic [BLOCK_W-1:0] data;
    } memory_response_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  memory_request_t  req [N_REQ],
    output memory_response_t res [N_REQ],
    output memory_request_t  mem_req,
    input  memory_response_t mem_res,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic              any_req;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    int unsigned       scan_base;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   next_ptr;
`endif

    // Winner scan: first asserted cs at or after the scan base, modulo N_REQ
    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        scan_base = 0;
`else
        scan_base = 32'(rr_ptr_q);
`endif
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((scan_base + k) % N_REQ);
            if (!any_req && req[cand].cs) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Round-robin successor of the current grant, wrapping at N_REQ-1
    always_comb begin
        next_ptr = grant_q + 1'b1;
        if (grant_q == ID_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end
    end
`endif

    // Next-state logic: IDLE -> GRANT on any request, GRANT -> RELEASE on ack
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // An aborted request (cs dropped) still waits here for the ack
                if (mem_res.ack) begin
                    state_d = RELEASE;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_ptr_d = next_ptr;
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and pointer registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Output routing: pass the granted request through, gate acks to the grantee
    always_comb begin
        mem_req = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            res[i].ack  = (state_q == GRANT) && (grant_q == ID_W'(i)) && mem_res.ack;
            res[i].data = mem_res.data;
        end
        if (state_q == GRANT) begin
            mem_req = req[grant_q];
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small block-memory
// controller model (acks in the 5th cycle after leaving idle).

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned ID_W  = 1;
    localparam logic [127:0] PAT  = 128'h0f0e0d0c0b0a09080706050403020100;

    logic             clk = 1'b0;
    logic             rst;
    memory_request_t  req [N_REQ];
    memory_response_t res [N_REQ];
    memory_request_t  mem_req;
    memory_response_t mem_res;
    logic [ID_W-1:0]  grant_id;
    logic             busy;

    logic             spur_ack;
    logic             m_busy, m_ack, m_rw;
    logic [2:0]       m_cnt;
    logic [31:0]      m_addr;
    logic [127:0]     m_wdata, m_rdata;
    logic [127:0]     mem [16];

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.N_REQ(N_REQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .res      (res),
        .mem_req  (mem_req),
        .mem_res  (mem_res),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Controller model: latches the request when idle, acks once, then idles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_ack   <= 1'b0;
            m_cnt   <= '0;
            m_rw    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (!m_busy) begin
            m_ack <= 1'b0;
            if (mem_req.cs) begin
                m_busy  <= 1'b1;
                m_cnt   <= '0;
                m_rw    <= mem_req.rw;
                m_addr  <= mem_req.addr;
                m_wdata <= mem_req.data;
            end
        end else begin
            m_cnt <= m_cnt + 3'd1;
            if (m_cnt == 3'd3) begin
                m_ack <= 1'b1;
                if (m_rw) mem[m_addr[7:4]] <= m_wdata;
                else      m_rdata <= mem[m_addr[7:4]];
            end
            if (m_cnt == 3'd4) begin
                m_ack  <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_res.ack  = m_ack | spur_ack;
        mem_res.data = m_rdata;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Called at the first negedge of GRANT; returns at the RELEASE negedge
    task automatic serve(input int id, input string tag, input bit drop,
                         input bit chk_pass, input bit chk_data, input logic [127:0] exp_data);
        int cyc;
        check({tag, "_grant"}, grant_id, id);
        check({tag, "_cs"}, mem_req.cs, 1);
        check({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!mem_res.ack && cyc < 20) begin
            if (chk_pass) check({tag, "_pass"}, mem_req, req[id]);
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 5);
        check({tag, "_ack"}, res[id].ack, 1);
        check({tag, "_ack_other"}, res[1 - id].ack, 0);
        if (chk_data) begin
            check({tag, "_data0"}, res[0].data, exp_data);
            check({tag, "_data1"}, res[1].data, exp_data);
        end
        if (drop) req[id].cs = 1'b0;
        tick();
        check({tag, "_rel_cs"}, mem_req.cs, 0);
        check({tag, "_rel_busy"}, busy, 1);
        check({tag, "_rel_ack"}, res[id].ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first;
        int low;
        int cyc;
        rst = 1'b1;
        spur_ack = 1'b0;
        for (int i = 0; i < N_REQ; i++) req[i] = '0;
        tick();
        tick();

        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_mem_req", mem_req, '0);
        check("rst_ack0", res[0].ack, 0);
        check("rst_ack1", res[1].ack, 0);
        rst = 1'b0;
        tick();

        // Single read from requester 0
        req[0].cs = 1'b1; req[0].rw = 1'b0; req[0].addr = 32'h40;
        #1 check("rd_idle_cs", mem_req.cs, 0);
        tick();
        check("rd_addr", mem_req.addr, 32'h40);
        check("rd_rw", mem_req.rw, 0);
        serve(0, "rd", 1, 0, 0, '0);
        tick();
        check("rd_idle_busy", busy, 0);
        check("rd_idle_cs", mem_req.cs, 0);

        // Contention from reset: 0 first, 1 after RELEASE + IDLE
        do_reset();
        req[0].cs = 1'b1; req[0].addr = 32'h100;
        req[1].cs = 1'b1; req[1].addr = 32'h200;
        tick();
        serve(0, "ct0", 1, 0, 0, '0);
        tick();
        check("ct_gap_busy", busy, 0);
        check("ct_gap_cs", mem_req.cs, 0);
        tick();
        serve(1, "ct1", 1, 0, 0, '0);
        tick();
        check("ct_idle_busy", busy, 0);

        // Serve 0 alone so the pointer sits at 1, then contend again
        req[0].cs = 1'b1;
        tick();
        serve(0, "bump", 1, 0, 0, '0);
        tick();
        req[0].cs = 1'b1;
        req[1].cs = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        first = 0;
`else
        first = 1;
`endif
        tick();
        serve(first, "rr_a", 1, 0, 0, '0);
        tick();
        tick();
        serve(1 - first, "rr_b", 1, 0, 0, '0);
        tick();

        // Write pass-through, then read back
        req[1].cs = 1'b1; req[1].rw = 1'b1; req[1].addr = 32'h80; req[1].data = PAT;
        tick();
        serve(1, "wr", 1, 1, 0, '0);
        req[1].rw = 1'b0; req[1].data = '0;
        tick();
        req[0].cs = 1'b1; req[0].rw = 1'b0; req[0].addr = 32'h80;
        tick();
        serve(0, "rb", 1, 0, 1, PAT);
        tick();

        // Reset two cycles into GRANT; requester 1 keeps cs high
        req[1].cs = 1'b1; req[1].addr = 32'h40;
        tick();
        check("rm_grant", grant_id, 1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rm_cs", mem_req.cs, 0);
        check("rm_busy", busy, 0);
        check("rm_grant0", grant_id, 0);
        tick();
        rst = 1'b0;
        tick();
        serve(1, "rm_after", 1, 0, 0, '0);
        tick();

        // Hold cs through RELEASE: re-granted after one IDLE cycle
        req[0].cs = 1'b1; req[0].addr = 32'h40;
        tick();
        serve(0, "gp", 0, 0, 0, '0);
        low = 1;
        tick();
        if (!mem_req.cs) low++;
        check("gp_idle_busy", busy, 0);
        tick();
        check("gp_regrant_cs", mem_req.cs, 1);
        check("gp_regrant_id", grant_id, 0);
        check("gp_low_cycles", low, 2);

        // Abort: drop cs mid-GRANT, arbiter still waits for the ack
        tick();
        tick();
        req[0].cs = 1'b0;
        #1;
        check("ab_cs", mem_req.cs, 0);
        check("ab_busy", busy, 1);
        cyc = 2;
        while (!mem_res.ack && cyc < 20) begin
            tick();
            cyc++;
            if (!mem_res.ack) check("ab_wait_busy", busy, 1);
        end
        check("ab_latency", cyc, 5);
        check("ab_ack", res[0].ack, 1);
        tick();
        check("ab_rel_busy", busy, 1);
        tick();
        check("ab_idle_busy", busy, 0);

        // Spurious ack in IDLE is not forwarded
        spur_ack = 1'b1;
        #1;
        check("sp_ack0", res[0].ack, 0);
        check("sp_ack1", res[1].ack, 0);
        tick();
        check("sp_busy", busy, 0);
        spur_ack = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
